// File: rtl/pool_relu_if.sv
// pool_relu_if: streaming handshake between the conv stage, pool_relu and its consumer
interface pool_relu_if;
  logic        v_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        v_o;
  logic [31:0] data_o;
  logic        ready_i;
  logic        done_o;
  modport slave (input v_i, data_i, ready_i, output ready_o, v_o, data_o, done_o);
  modport master(output v_i, data_i, ready_i, input ready_o, v_o, data_o, done_o);
endinterface

// File: rtl/pool_relu.sv
// pool_relu: ReLU then 2x2 stride-2 max pooling over a raster-streamed multi-channel frame
module pool_relu #(
  parameter int M_p = 4,
  parameter int R_p = 16,
  parameter int C_p = 16
) (
  input logic       clk_i,
  input logic       reset_i,
  pool_relu_if.slave bus
);
  localparam int CW = $clog2(C_p);
  localparam int RW = $clog2(R_p);
  localparam int MW = M_p > 1 ? $clog2(M_p) : 1;
  localparam int HW = C_p > 2 ? $clog2(C_p / 2) : 1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [MW-1:0] ch;
  logic [HW-1:0] half;
  logic [31:0]   hold, r;
  logic [31:0]   lb [C_p/2];
  logic          acc, lc, lr, lm, fin;
  // ReLU output is never negative, so unsigned compare of the bit patterns equals IEEE '>'
  function automatic logic [31:0] mx(input logic [31:0] a, input logic [31:0] b);
    return (b > a) ? b : a;
  endfunction
  assign bus.ready_o = ~bus.v_o | bus.ready_i;
  assign acc  = bus.v_i & bus.ready_o;
  assign r    = (!bus.data_i[31] && |bus.data_i[30:0]) ? bus.data_i : '0;
  assign half = HW'(col >> 1);
  assign lc   = col == CW'(C_p - 1);
  assign lr   = row == RW'(R_p - 1);
  assign lm   = ch == MW'(M_p - 1);
  always_ff @(posedge clk_i)
    if (acc && !row[0] && col[0]) lb[half] <= mx(hold, r);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col        <= '0;
      row        <= '0;
      ch         <= '0;
      hold       <= '0;
      fin        <= 1'b0;
      bus.v_o    <= 1'b0;
      bus.done_o <= 1'b0;
      bus.data_o <= '0;
    end else begin
      bus.done_o <= bus.v_o & bus.ready_i & fin;
      if (bus.v_o && bus.ready_i) bus.v_o <= 1'b0;
      if (acc) begin
        col <= lc ? '0 : col + 1'b1;
        if (lc) row <= lr ? '0 : row + 1'b1;
        if (lc && lr) ch <= lm ? '0 : ch + 1'b1;
        if (!row[0] && !col[0]) hold <= r;
        if (row[0] && !col[0]) hold <= mx(lb[half], r);
        if (row[0] && col[0]) begin
          bus.data_o <= mx(hold, r);
          bus.v_o    <= 1'b1;
          fin        <= lc & lr & lm;
        end
      end
    end
  end
endmodule

// File: tb/tb_pool_relu.sv
// tb_pool_relu: directed checks of pool_relu on a 1x2x2 and a 2x4x4 configuration
module tb_pool_relu;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  pool_relu_if ia();
  pool_relu_if ib();
  pool_relu #(.M_p(1), .R_p(2), .C_p(2)) dut_a(.clk_i(clk), .reset_i(reset), .bus(ia.slave));
  pool_relu #(.M_p(2), .R_p(4), .C_p(4)) dut_b(.clk_i(clk), .reset_i(reset), .bus(ib.slave));
  int tests = 0, fails = 0, stalls = 0, done_cnt = 0;
  logic [31:0] q[$];
  logic [31:0] exp37[8];
  int vals[8] = '{5, 7, 13, 15, 105, 107, 113, 115};

  // Exact single-precision encoding of a small non-negative integer
  function automatic logic [31:0] fp(input int v);
    int m;
    logic [31:0] x;
    if (v == 0) return '0;
    m = 0;
    for (int i = 0; i < 31; i++) if (v[i]) m = i;
    x = v;
    x = x << (23 - m);
    return {1'b0, 8'(127 + m), x[22:0]};
  endfunction

  always @(negedge clk) begin
    if (ib.v_o && ib.ready_i) q.push_back(ib.data_o);
    if (ib.done_o) done_cnt++;
  end

  task automatic send_b(input logic [31:0] d);
    int n;
    logic ok;
    ib.v_i = 1;
    ib.data_i = d;
    n = 0;
    ok = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = ib.ready_o;
      if (!ok) stalls++;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_b_timeout got ready_o=0 expected ready_o=1 within 100 cycles");
    end
  endtask

  task automatic stream_b();
    for (int c = 0; c < 2; c++)
      for (int rr = 0; rr < 4; rr++)
        for (int k = 0; k < 4; k++) send_b(fp(c * 100 + rr * 4 + k));
  endtask

  task automatic drain_b();
    ib.v_i = 0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    ia.ready_i = 0; ib.ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (ia.v_o !== 1'b0) begin fails++; $display("FAIL reset_a_v_o got %b expected 0", ia.v_o); end
    tests++; if (ia.done_o !== 1'b0) begin fails++; $display("FAIL reset_a_done got %b expected 0", ia.done_o); end
    tests++; if (ia.data_o !== 32'h0) begin fails++; $display("FAIL reset_a_data got %h expected 00000000", ia.data_o); end
    tests++; if (ib.v_o !== 1'b0) begin fails++; $display("FAIL reset_b_v_o got %b expected 0", ib.v_o); end
    tests++; if (ib.data_o !== 32'h0) begin fails++; $display("FAIL reset_b_data got %h expected 00000000", ib.data_o); end
    reset = 0;
    #1;
    tests++; if (ia.ready_o !== 1'b1) begin fails++; $display("FAIL reset_a_ready got %b expected 1", ia.ready_o); end
    tests++; if (ib.ready_o !== 1'b1) begin fails++; $display("FAIL reset_b_ready got %b expected 1", ib.ready_o); end
    ia.ready_i = 1; ib.ready_i = 1;
  endtask

  task automatic test_single();
    logic [31:0] d[4] = '{32'h3F800000, 32'hC0400000, 32'h40200000, 32'h3F000000};
    ia.v_i = 1;
    for (int i = 0; i < 4; i++) begin
      ia.data_i = d[i];
      @(posedge clk); #1;
    end
    ia.v_i = 0;
    tests++; if (ia.v_o !== 1'b1) begin fails++; $display("FAIL single_v_o got %b expected 1", ia.v_o); end
    tests++; if (ia.data_o !== 32'h40200000) begin fails++; $display("FAIL single_data got %h expected 40200000", ia.data_o); end
    tests++; if (ia.done_o !== 1'b0) begin fails++; $display("FAIL single_done_early got %b expected 0", ia.done_o); end
    @(posedge clk); #1;
    tests++; if (ia.v_o !== 1'b0) begin fails++; $display("FAIL single_v_o_clear got %b expected 0", ia.v_o); end
    tests++; if (ia.done_o !== 1'b1) begin fails++; $display("FAIL single_done got %b expected 1", ia.done_o); end
    @(posedge clk); #1;
    tests++; if (ia.done_o !== 1'b0) begin fails++; $display("FAIL single_done_pulse got %b expected 0", ia.done_o); end
  endtask

  task automatic test_negative();
    ia.v_i = 1;
    ia.data_i = 32'hBF800000;
    repeat (4) @(posedge clk);
    #1;
    ia.v_i = 0;
    tests++; if (ia.v_o !== 1'b1) begin fails++; $display("FAIL neg_v_o got %b expected 1", ia.v_o); end
    tests++; if (ia.data_o !== 32'h0) begin fails++; $display("FAIL neg_data got %h expected 00000000", ia.data_o); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    q.delete(); stalls = 0; done_cnt = 0;
    stream_b();
    drain_b();
    tests++; if (q.size() != 8) begin fails++; $display("FAIL stream_count got %0d expected 8", q.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= q.size() || q[i] !== exp37[i]) begin
        fails++; $display("FAIL stream_out[%0d] got %h expected %h", i, i < q.size() ? q[i] : 32'hx, exp37[i]);
      end
    end
    tests++; if (stalls != 0) begin fails++; $display("FAIL stream_bubbles got %0d expected 0", stalls); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL stream_done got %0d expected 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    q.delete(); done_cnt = 0;
    fork
      stream_b();
      begin
        int n;
        logic [31:0] held;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ib.v_o && n < 200);
        if (!ib.v_o) begin
          tests++; fails++; $display("FAIL bp_wait got v_o=0 expected v_o=1 within 200 cycles");
        end else begin
          ib.ready_i = 0;
          held = ib.data_o;
          repeat (3) begin
            @(negedge clk);
            tests++; if (ib.ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready got %b expected 0", ib.ready_o); end
            tests++; if (ib.v_o !== 1'b1) begin fails++; $display("FAIL bp_v_o got %b expected 1", ib.v_o); end
            tests++; if (ib.data_o !== held) begin fails++; $display("FAIL bp_hold got %h expected %h", ib.data_o, held); end
            @(posedge clk); #1;
          end
          ib.ready_i = 1;
        end
      end
    join
    drain_b();
    tests++; if (q.size() != 8) begin fails++; $display("FAIL bp_count got %0d expected 8", q.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= q.size() || q[i] !== exp37[i]) begin
        fails++; $display("FAIL bp_out[%0d] got %h expected %h", i, i < q.size() ? q[i] : 32'hx, exp37[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    q.delete(); done_cnt = 0;
    for (int i = 0; i < 5; i++) send_b(fp(i));
    ib.v_i = 0;
    ib.ready_i = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    #1;
    tests++; if (ib.ready_o !== 1'b1) begin fails++; $display("FAIL mid_ready got %b expected 1", ib.ready_o); end
    ib.ready_i = 1;
    stream_b();
    drain_b();
    tests++; if (q.size() != 8) begin fails++; $display("FAIL mid_count got %0d expected 8", q.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= q.size() || q[i] !== exp37[i]) begin
        fails++; $display("FAIL mid_out[%0d] got %h expected %h", i, i < q.size() ? q[i] : 32'hx, exp37[i]);
      end
    end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL mid_done got %0d expected 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    q.delete(); done_cnt = 0;
    stream_b();
    stream_b();
    drain_b();
    tests++; if (q.size() != 16) begin fails++; $display("FAIL b2b_count got %0d expected 16", q.size()); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (i >= q.size() || q[i] !== exp37[i % 8]) begin
        fails++; $display("FAIL b2b_out[%0d] got %h expected %h", i, i < q.size() ? q[i] : 32'hx, exp37[i % 8]);
      end
    end
    tests++; if (done_cnt != 2) begin fails++; $display("FAIL b2b_done got %0d expected 2", done_cnt); end
  endtask

  initial begin
    ia.v_i = 0; ia.data_i = '0; ia.ready_i = 0;
    ib.v_i = 0; ib.data_i = '0; ib.ready_i = 0;
    for (int i = 0; i < 8; i++) exp37[i] = fp(vals[i]);
    test_reset();
    test_single();
    test_negative();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pool_relu.md
POOL_RELU -- requirements
Module: pool_relu

Interface
REQ-001 SHALL have parameter M_p, default 4: number of output feature maps (channels) per frame.
REQ-002 SHALL have parameter R_p, default 16: input rows per channel; even, >=2.
REQ-003 SHALL have parameter C_p, default 16: input columns per channel; even, >=2.
REQ-004 SHALL have port clk_i  input  1  clock; one clock domain, all state updates on its rising edge.
REQ-005 SHALL have port reset_i  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port v_i  input  1  upstream data valid.
REQ-007 SHALL have port data_i  input  shortreal (32)  conv-stage output pixel.
REQ-008 SHALL have port ready_o  output  1  block can accept data_i this cycle.
REQ-009 SHALL have port v_o  output  1  pooled result valid.
REQ-010 SHALL have port data_o  output  shortreal (32)  pooled result.
REQ-011 SHALL have port ready_i  input  1  downstream can accept data_o.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse after the last pooled value of the frame is consumed.

Function
REQ-013 SHALL accept a beat when v_i & ready_o; input order: channel 0..M_p-1, within each channel row 0..R_p-1, within each row col 0..C_p-1.
REQ-014 SHALL track position with counters col (0..C_p-1), row (0..R_p-1), ch (0..M_p-1); each accepted beat advances col; col wrap advances row; row wrap advances ch; ch wrap returns all to 0 (frame end).
REQ-015 SHALL apply ReLU to each accepted value: r = (x > 0.0) ? x : +0.0; -0.0 and negatives give +0.0.
REQ-016 SHALL compute 2x2, stride-2 max pooling on r values: output (ch, row/2, col/2) = max of the four r values of that window.
REQ-017 SHALL hold a line buffer of C_p/2 shortreal partial maxima plus one hold register.
REQ-018 Even row, even col: hold <= r.
REQ-019 Even row, odd col: buf[col/2] <= max(hold, r).
REQ-020 Odd row, even col: hold <= max(buf[col/2], r).
REQ-021 Odd row, odd col: data_o <= max(hold, r); v_o <= 1.
REQ-022 SHALL emit (R_p/2)*(C_p/2) outputs per channel, in raster order of the pooled map, channels in order.
REQ-023 SHALL set v_o one cycle after the beat completing a window is accepted; latency = 1 cycle.
REQ-024 SHALL drive ready_o = ~v_o | ready_i, combinationally.
REQ-025 SHALL clear v_o when v_o & ready_i and no new window completes that cycle; a simultaneous completing beat reloads data_o and keeps v_o = 1.
REQ-026 SHALL hold data_o and v_o stable while v_o & ~ready_i.
REQ-027 SHALL sustain one input beat per cycle when ready_i is held high.
REQ-028 SHALL pulse done_o for exactly one cycle on the cycle after the final output of channel M_p-1 is consumed (v_o & ready_i); counters are already back at 0, so the next frame may start immediately.
REQ-029 SHALL ignore data_i when v_i is low, and SHALL not advance counters or modify buffers.
REQ-030 SHALL perform max comparisons with IEEE single '>'; ties select either operand (values are equal). NaN inputs are unsupported and not verified.

Reset
REQ-031 While reset_i is high at a clock edge: col, row, ch <= 0; v_o <= 0; done_o <= 0; data_o <= +0.0; hold <= +0.0.
REQ-032 Line buffer contents need not be reset; they are always written before being read.
REQ-033 Reset asserted mid-frame SHALL abandon the partial frame; the first beat accepted after reset is treated as ch 0, row 0, col 0.
REQ-034 ready_o SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 M_p=1, R_p=C_p=2, inputs 1.0, -3.0, 2.5, 0.5, ready_i=1 -> one output 2.5, v_o high 1 cycle after the 4th beat; done_o pulses the following cycle.
REQ-036 M_p=1, R_p=C_p=2, all inputs -1.0 -> output +0.0 (sign bit 0).
REQ-037 M_p=2, R_p=C_p=4, input value = ch*100 + row*4 + col, streamed back-to-back -> outputs 5, 7, 13, 15, 105, 107, 113, 115, in that order; no bubbles on ready_o.
REQ-038 Same stream with ready_i low for 3 cycles while v_o=1 -> data_o held constant, ready_o=0, no value lost or duplicated; the sequence matches REQ-037.
REQ-039 Reset pulsed after 5 beats of a 4x4 frame, then the full REQ-037 stream is sent -> exactly the REQ-037 outputs; nothing from the partial frame is emitted.
REQ-040 Two consecutive frames with no idle cycle between them -> done_o pulses once per frame; the second frame's outputs are correct.
